// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
//  - Combines single-cycle stall requests from pipeline stages with a
//    multi-cycle (mul/div) stall FSM into one stall mask.
//  - Exceptions/redirects produce a registered one-cycle flush pulse and
//    redirect PC, and cancel any multi-cycle operation in flight.
//  - Optional feature macro: STALL_PERF_EN adds stall_cycles and flush_count
//    performance counters.
module pipe_ctrl #(
    parameter int                 STALL_W   = 6,
    parameter int                 REQ_N     = 2,
    parameter logic [4*REQ_N-1:0] REQ_STAGE = {4'd4, 4'd2},
    parameter int                 MC_STAGE  = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [REQ_N-1:0]   stallreq,
    input  logic               mc_start,
    input  logic [7:0]         mc_cycles,
    input  logic               excp_req,
    input  logic [31:0]        excp_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               mc_done
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_count
`endif
);

    // Mask that freezes stage s and every earlier stage (bit 0 is the PC).
    // Stages beyond the bus width saturate to all ones.
    function automatic logic [STALL_W-1:0] mask_of(input int s);
        logic [STALL_W-1:0] m;
        m = '0;
        for (int k = 0; k < STALL_W; k++) begin
            if (k <= s) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [STALL_W-1:0] MC_MASK = mask_of(MC_STAGE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    mc_state_t          state_reg;
    mc_state_t          state_next;
    logic [7:0]         cnt_reg;
    logic [7:0]         cnt_next;
    logic               flush_reg;
    logic [31:0]        new_pc_reg;
    logic               mc_stall;
    logic               mc_done_next;
    logic [STALL_W-1:0] stall_raw;
    logic [STALL_W-1:0] req_mask [REQ_N];

    // Per-source mask, only contributing while that source is requesting.
    generate
        for (genvar gi = 0; gi < REQ_N; gi++) begin : g_req
            assign req_mask[gi] = stallreq[gi]
                                ? mask_of(int'(REQ_STAGE[gi*4 +: 4]))
                                : '0;
        end
    endgenerate

    // Multi-cycle FSM next state; an exception overrides everything and
    // abandons the operation without a completion pulse.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mc_stall     = 1'b0;
        mc_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mc_start && !excp_req) begin
                    // The start cycle itself is the first stalled cycle.
                    mc_stall = 1'b1;
                    if (mc_cycles <= 8'd1) begin
                        state_next = DONE;
                        cnt_next   = 8'd0;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = mc_cycles - 8'd1;
                    end
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                if (cnt_reg <= 8'd1) begin
                    state_next = DONE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            DONE: begin
                mc_done_next = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
        if (excp_req) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
        end
    end

    // FSM state and down-counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Flush pulse follows excp_req by one cycle; redirect PC holds otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_reg  <= 1'b0;
            new_pc_reg <= 32'h0;
        end else begin
            flush_reg <= excp_req;
            if (excp_req) begin
                new_pc_reg <= excp_pc;
            end
        end
    end

    // Stall mask: OR of all active requests, killed during reset or flush.
    always_comb begin
        stall_raw = mc_stall ? MC_MASK : '0;
        for (int i = 0; i < REQ_N; i++) begin
            stall_raw = stall_raw | req_mask[i];
        end
        stall = (!resetn || flush_reg) ? '0 : stall_raw;
    end

    assign flush   = flush_reg;
    assign new_pc  = new_pc_reg;
    assign mc_done = mc_done_next;

`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles_reg;
    logic [15:0] flush_count_reg;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_reg <= 32'd0;
            flush_count_reg  <= 16'd0;
        end else begin
            if (stall != '0) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (excp_req) begin
                flush_count_reg <= flush_count_reg + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven, cycle-by-cycle check of pipe_ctrl with a
// scoreboard queue of expected outputs, plus an asynchronous-reset sequence.
module tb_pipe_ctrl;

    logic        clk;
    logic        resetn;
    logic [1:0]  stallreq;
    logic        mc_start;
    logic [7:0]  mc_cycles;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_done;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    pipe_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .stallreq  (stallreq),
        .mc_start  (mc_start),
        .mc_cycles (mc_cycles),
        .excp_req  (excp_req),
        .excp_pc   (excp_pc),
        .stall     (stall),
        .flush     (flush),
        .new_pc    (new_pc),
        .mc_done   (mc_done)
`ifdef STALL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sr;
        logic        ms;
        logic [7:0]  n;
        logic        ex;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_done;
    } vec_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        done;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    localparam logic [31:0] PC_E = 32'hBFC00380;
    localparam logic [31:0] PC_A = 32'h11110000;
    localparam logic [31:0] PC_B = 32'h22220004;
    localparam logic [31:0] PC_C = 32'h80000000;

    function automatic void add(input logic [1:0] sr, input logic ms, input logic [7:0] n,
                                input logic ex, input logic [31:0] pc,
                                input logic [5:0] es, input logic ef, input logic [31:0] ep,
                                input logic ed);
        vec_t v;
        v.sr = sr; v.ms = ms; v.n = n; v.ex = ex; v.pc = pc;
        v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_done = ed;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare the
    // outputs once they have settled, well clear of the rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        stallreq  = v.sr;
        mc_start  = v.ms;
        mc_cycles = v.n;
        excp_req  = v.ex;
        excp_pc   = v.pc;
        e.stall = v.e_stall; e.flush = v.e_flush; e.pc = v.e_pc; e.done = v.e_done; e.idx = txn;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        $display("txn %0d sr=%b ms=%b n=%0d ex=%b | stall=%b flush=%b new_pc=%h mc_done=%b",
                 e.idx, v.sr, v.ms, v.n, v.ex, stall, flush, new_pc, mc_done);
        check($sformatf("stall[%0d]", e.idx),   {26'd0, stall},   {26'd0, e.stall});
        check($sformatf("flush[%0d]", e.idx),   {31'd0, flush},   {31'd0, e.flush});
        check($sformatf("new_pc[%0d]", e.idx),  new_pc,           e.pc);
        check($sformatf("mc_done[%0d]", e.idx), {31'd0, mc_done}, {31'd0, e.done});
        txn++;
    endtask

    initial begin
        vec_t v;
        stallreq  = 2'b11;
        mc_start  = 1'b0;
        mc_cycles = 8'd0;
        excp_req  = 1'b0;
        excp_pc   = 32'h0;
        resetn    = 1'b0;

        // Stall requests alone
        add(2'b00,0,0,0,0,     6'b000000,0,32'h0,0);
        add(2'b01,0,0,0,0,     6'b000111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b000000,0,32'h0,0);
        add(2'b11,0,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b10,0,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b000000,0,32'h0,0);
        // Multi-cycle N=5, with a stray mc_start while BUSY
        add(2'b00,1,5,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,1,3,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b000000,0,32'h0,1);
        add(2'b00,0,0,0,0,     6'b000000,0,32'h0,0);
        // N=0 (mc_start during DONE ignored), then N=1
        add(2'b00,1,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,1,5,0,0,     6'b000000,0,32'h0,1);
        add(2'b00,0,0,0,0,     6'b000000,0,32'h0,0);
        add(2'b00,1,1,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b000000,0,32'h0,1);
        // N=10 aborted by exception in the third BUSY cycle
        add(2'b00,1,10,0,0,    6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,0,0,     6'b011111,0,32'h0,0);
        add(2'b00,0,0,1,PC_E,  6'b011111,0,32'h0,0);
        add(2'b11,0,0,0,0,     6'b000000,1,PC_E,0);
        add(2'b00,0,0,0,0,     6'b000000,0,PC_E,0);
        add(2'b00,0,0,0,0,     6'b000000,0,PC_E,0);
        add(2'b00,0,0,0,0,     6'b000000,0,PC_E,0);
        // Back-to-back exceptions
        add(2'b00,0,0,1,PC_A,  6'b000000,0,PC_E,0);
        add(2'b00,0,0,1,PC_B,  6'b000000,1,PC_A,0);
        add(2'b00,0,0,0,0,     6'b000000,1,PC_B,0);
        add(2'b00,0,0,0,0,     6'b000000,0,PC_B,0);
        // Exception and mc_start together: exception wins
        add(2'b00,1,3,1,PC_C,  6'b000000,0,PC_B,0);
        add(2'b00,0,0,0,0,     6'b000000,1,PC_C,0);
        add(2'b00,0,0,0,0,     6'b000000,0,PC_C,0);
        add(2'b01,0,0,0,0,     6'b000111,0,PC_C,0);
        add(2'b00,0,0,0,0,     6'b000000,0,PC_C,0);
        // Start N=10 to be interrupted by reset
        add(2'b00,1,10,0,0,    6'b011111,0,PC_C,0);
        add(2'b00,0,0,0,0,     6'b011111,0,PC_C,0);
        add(2'b00,0,0,0,0,     6'b011111,0,PC_C,0);

        // Reset state, with requests asserted
        #3;
        check("rst_stall",   {26'd0, stall},   32'd0);
        check("rst_flush",   {31'd0, flush},   32'd0);
        check("rst_new_pc",  new_pc,           32'd0);
        check("rst_mc_done", {31'd0, mc_done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        stallreq = 2'b00;
        resetn   = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset mid-BUSY: outputs clear before the next edge
        stallreq = 2'b11;
        resetn   = 1'b0;
        #1;
        check("async_stall",   {26'd0, stall},   32'd0);
        check("async_flush",   {31'd0, flush},   32'd0);
        check("async_new_pc",  new_pc,           32'd0);
        check("async_mc_done", {31'd0, mc_done}, 32'd0);
        @(negedge clk);
        resetn   = 1'b1;
        stallreq = 2'b00;

        // After release the abandoned operation never stalls or completes
        for (int i = 0; i < 12; i++) begin
            v.sr = 2'b00; v.ms = 1'b0; v.n = 8'd0; v.ex = 1'b0; v.pc = 32'h0;
            v.e_stall = 6'b0; v.e_flush = 1'b0; v.e_pc = 32'h0; v.e_done = 1'b0;
            apply(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
